spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 27000000, system clock in Hz.
REQ-002 SHALL have parameter SPI_FREQUENCY, default 1000000, target SCK in Hz; HALF_DIV = CLOCK_FREQUENCY/(2*SPI_FREQUENCY), integer-truncated, minimum 1.
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  byte to transmit, sampled with tx_start.
REQ-006 SHALL have port tx_start  input  1  request; accepted only in a cycle where tx_ready=1.
REQ-007 SHALL have port tx_ready  output  1  master can accept a byte this cycle.
REQ-008 SHALL have port rx_data  output  8  byte received on spi_miso; held until next rx_valid.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-010 SHALL have ports spi_clk, spi_cs, spi_mosi (outputs, 1 bit) and spi_miso (input, 1 bit); spi_cs active-low.

Function
REQ-011 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
REQ-012 SHALL use states IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP.
REQ-013 IDLE: tx_ready=1, spi_cs=1, spi_clk=0; on tx_start, latch tx_data, go CS_SETUP next cycle.
REQ-014 CS_SETUP: spi_cs=0, spi_mosi=bit7, spi_clk=0 for HALF_DIV cycles, then SHIFT.
REQ-015 SHIFT: spi_clk toggles every HALF_DIV cycles; spi_miso sampled into shift register on each rising spi_clk; spi_mosi advances on each falling spi_clk; exactly 8 rising edges.
REQ-016 After 8th falling edge spi_clk SHALL stay 0; state CS_HOLD for HALF_DIV cycles with spi_cs=0.
REQ-017 On CS_HOLD exit: spi_cs=1, rx_data=received byte, rx_valid=1 for exactly one cycle, go CS_GAP.
REQ-018 CS_GAP: spi_cs=1 for HALF_DIV cycles, tx_ready=0, then IDLE.
REQ-019 tx_start while tx_ready=0 SHALL be ignored; no queuing.
REQ-020 spi_miso is sampled directly (synchronous master-generated SCK); no double-flop required.
REQ-021 Byte time, start accept to rx_valid: (2 + 16 + ... ) = 18*HALF_DIV + 1 cycles, exactly.

Reset
REQ-022 reset SHALL force IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, tx_ready=1, rx_valid=0, rx_data=0x00, divider and bit counters 0.
REQ-023 reset mid-transfer SHALL abort in the same cycle; no rx_valid for the aborted byte.

Configuration
REQ-024 Macro SPI_MASTER_BURST_EN SHALL enable burst mode: tx_ready=1 also during the final CS_HOLD cycle; tx_start there latches a new byte, skips CS_GAP, keeps spi_cs=0 and enters CS_SETUP; rx_valid still pulses per byte.
REQ-025 Without SPI_MASTER_BURST_EN, spi_cs SHALL rise between every byte for at least HALF_DIV cycles; tx_ready only in IDLE.

Structure
REQ-026 Package spi_pkg SHALL hold the state enumeration, frame width (8) and HALF_DIV computation helper.
REQ-027 Sub-module spi_clk_div SHALL generate the HALF_DIV tick (enable-gated counter); shift/state logic stays in spi_master.

Verification
REQ-028 CLOCK_FREQUENCY=27000000, SPI_FREQUENCY=6750000 (HALF_DIV=2), miso looped to mosi, send 0xA5 -> rx_data=0xA5, rx_valid once, 37 cycles after accept.
REQ-029 Model slave returns 0x3C while master sends 0xFF -> rx_data=0x3C; mosi high all 8 bits; 8 spi_clk rising edges.
REQ-030 tx_start pulsed mid-SHIFT with 0x11 -> ignored; only original byte transferred, one rx_valid.
REQ-031 reset asserted at 4th rising spi_clk -> next cycle spi_cs=1, spi_clk=0, tx_ready=1, no rx_valid; subsequent 0x5A transfer correct.
REQ-032 SPI_MASTER_BURST_EN, bytes 0x01,0x02,0x03 back-to-back -> spi_cs low continuously, 24 rising edges, three rx_valid pulses; without macro -> spi_cs high >=2 cycles between bytes.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM state encoding, frame width
// and the half-period divider computation.
package spi_pkg;

  localparam int unsigned FrameWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StCsGap
  } spi_state_e;

  // System clocks per SCK half-period, truncated, never below one.
  function automatic int unsigned calc_half_div(int unsigned clk_hz, int unsigned spi_hz);
    int unsigned div;
    if (spi_hz == 0) begin
      return 1;
    end
    div = clk_hz / (2 * spi_hz);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Enable-gated half-period tick generator; the count restarts from zero whenever
// the enable drops, so the first tick after enabling arrives HalfDiv cycles later.
module spi_clk_div #(
  parameter int unsigned HalfDiv = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(HalfDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, one 8-bit frame per request. Defining
// SPI_MASTER_BURST_EN lets a new byte be accepted in the last CS_HOLD cycle.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned SPI_FREQUENCY   = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int unsigned HalfDiv = calc_half_div(CLOCK_FREQUENCY, SPI_FREQUENCY);
  localparam int unsigned HalfW = $clog2(2 * FrameWidth);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(2 * FrameWidth - 1);

  spi_state_e state_q, state_d;
  logic [FrameWidth-1:0] tx_sh_q, tx_sh_d;
  logic [FrameWidth-1:0] rx_sh_q, rx_sh_d;
  logic [FrameWidth-1:0] rx_data_q, rx_data_d;
  logic [HalfW-1:0] half_q, half_d;
  logic sclk_q, sclk_d;
  logic rx_valid_q, rx_valid_d;
  logic tick;
  logic div_en;
  logic burst_ok;

  assign div_en = (state_q != StIdle);

  spi_clk_div #(
    .HalfDiv(HalfDiv)
  ) u_clk_div (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (div_en),
    .tick_o(tick)
  );

`ifdef SPI_MASTER_BURST_EN
  assign burst_ok = 1'b1;
`else
  assign burst_ok = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    half_d     = half_q;
    sclk_d     = sclk_q;
    rx_valid_d = 1'b0;
    tx_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_ready = 1'b1;
        if (tx_start) begin
          tx_sh_d = tx_data;
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        // SHIFT opens with the first rising SCK edge, so capture bit 7 here.
        if (tick) begin
          state_d = StShift;
          sclk_d  = 1'b1;
          half_d  = '0;
          rx_sh_d = {rx_sh_q[FrameWidth-2:0], spi_miso};
        end
      end
      StShift: begin
        if (tick) begin
          if (half_q == HalfLast) begin
            state_d = StCsHold;
          end else begin
            half_d = half_q + HalfW'(1);
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              rx_sh_d = {rx_sh_q[FrameWidth-2:0], spi_miso};
            end else begin
              tx_sh_d = {tx_sh_q[FrameWidth-2:0], 1'b0};
            end
          end
        end
      end
      StCsHold: begin
        tx_ready = burst_ok && tick;
        if (tick) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          if (burst_ok && tx_start) begin
            tx_sh_d = tx_data;
            state_d = StCsSetup;
          end else begin
            state_d = StCsGap;
          end
        end
      end
      StCsGap: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      half_q     <= '0;
      sclk_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      half_q     <= half_d;
      sclk_q     <= sclk_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // The transmit shifter fills with zeros, so MOSI rests low outside a frame.
  assign spi_mosi = tx_sh_q[FrameWidth-1];
  assign spi_clk  = sclk_q;
  assign spi_cs   = !(state_q == StCsSetup || state_q == StShift || state_q == StCsHold);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: vector table, randomized transfers against a
// byte-level reference, plus hand-written abort, ignored-start and multi-byte sequences.
module tb_spi_master;

  localparam int unsigned ClkHz = 27000000;
  localparam int unsigned SpiHz = 6750000;
  localparam int unsigned HalfRaw = ClkHz / (2 * SpiHz);
  localparam int unsigned HalfDiv = (HalfRaw < 1) ? 1 : HalfRaw;
  localparam int unsigned ByteCycles = 18 * HalfDiv + 1;

  logic       clock;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso;

  bit         loopback = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_sh = 8'h00;
  logic       slave_miso = 1'b0;
  logic       s_prev_cs = 1'b1;
  logic       s_prev_clk = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rises_total = 0;
  int rxv_total = 0;
  int last_acc_cyc = 0;
  int last_rxv_cyc = 0;
  logic [7:0] mosi_hist = 8'h00;
  logic       prev_sclk = 1'b0;

  spi_master #(
    .CLOCK_FREQUENCY(ClkHz),
    .SPI_FREQUENCY  (SpiHz)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .spi_clk (spi_clk),
    .spi_cs  (spi_cs),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  assign spi_miso = loopback ? spi_mosi : slave_miso;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Mode-0 slave: first bit presented when CS falls, next bit after each falling SCK.
  always @(spi_cs, spi_clk) begin
    if (!spi_cs && s_prev_cs) begin
      slave_sh   = slave_byte;
      slave_miso = slave_sh[7];
    end else if (!spi_cs && !spi_clk && s_prev_clk) begin
      slave_sh   = {slave_sh[6:0], 1'b0};
      slave_miso = slave_sh[7];
    end
    s_prev_cs  = spi_cs;
    s_prev_clk = spi_clk;
  end

  always @(negedge clock) begin
    if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
      rises_total++;
      mosi_hist = {mosi_hist[6:0], spi_mosi};
    end
    prev_sclk = spi_clk;
    if (rx_valid === 1'b1) begin
      rxv_total++;
      last_rxv_cyc = cyc;
    end
    if (tx_start === 1'b1 && tx_ready === 1'b1) last_acc_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(tx_ready === 1'b1 && spi_cs === 1'b1) && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) check({tag, " idle timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_byte(input logic [7:0] tx, input logic [7:0] slv, input bit loop,
                          input logic [7:0] exp_rx, input bit mid_pulse, input string tag);
    int rises0, rxv0, n;
    loopback   = loop;
    slave_byte = slv;
    wait_idle(tag);
    rises0   = rises_total;
    rxv0     = rxv_total;
    tx_data  = tx;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    if (mid_pulse) begin
      tick(6 * HalfDiv);
      tx_data  = 8'h11;
      tx_start = 1'b1;
      tick(1);
      tx_start = 1'b0;
      tx_data  = 8'h00;
    end
    n = 0;
    while (rxv_total == rxv0 && n < 4 * ByteCycles) begin
      tick(1);
      n++;
    end
    if (n >= 4 * ByteCycles) check({tag, " rx_valid timeout"}, 32'd0, 32'd1);
    wait_idle(tag);
    tick(mid_pulse ? ByteCycles + 8 : 2 * HalfDiv + 4);
    check({tag, " rx_data"}, 32'(rx_data), 32'(exp_rx));
    check({tag, " rx_valid count"}, 32'(rxv_total - rxv0), 32'd1);
    check({tag, " sck rises"}, 32'(rises_total - rises0), 32'd8);
    check({tag, " mosi bits"}, 32'(mosi_hist), 32'(tx));
    check({tag, " latency"}, 32'(last_rxv_cyc - last_acc_cyc), 32'(ByteCycles));
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    bit         loop;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] burst_bytes[3];
  logic [7:0] rxq[$];

  initial begin
    logic [7:0] rtx, rslv;
    bit rloop;
    int n, rises0, rxv0, idx, cs_rises, gap, min_gap;
    bit prev_cs, seen_low, prev_clk_t;

    vecs[0] = '{tx: 8'hA5, slv: 8'h00, loop: 1'b1, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, slv: 8'h3C, loop: 1'b0, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h00, slv: 8'hFF, loop: 1'b0, exp_rx: 8'hFF};
    vecs[3] = '{tx: 8'h5A, slv: 8'h81, loop: 1'b0, exp_rx: 8'h81};
    burst_bytes[0] = 8'h01;
    burst_bytes[1] = 8'h02;
    burst_bytes[2] = 8'h03;

    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    tick(3);
    check("reset spi_cs", 32'(spi_cs), 32'd1);
    check("reset spi_clk", 32'(spi_clk), 32'd0);
    check("reset spi_mosi", 32'(spi_mosi), 32'd0);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 4; i++) begin
      run_byte(vecs[i].tx, vecs[i].slv, vecs[i].loop, vecs[i].exp_rx, 1'b0,
               $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rtx   = 8'($urandom_range(0, 255));
      rslv  = 8'($urandom_range(0, 255));
      rloop = 1'($urandom_range(0, 1));
      run_byte(rtx, rslv, rloop, rloop ? rtx : rslv, 1'b0, $sformatf("rand%0d", i));
    end

    run_byte(8'hC3, 8'h96, 1'b0, 8'h96, 1'b1, "ignored start");

    // Abort on the 4th rising SCK edge.
    loopback   = 1'b0;
    slave_byte = 8'hE7;
    wait_idle("abort");
    rxv0     = rxv_total;
    tx_data  = 8'hE7;
    tx_start = 1'b1;
    tick(1);
    tx_start   = 1'b0;
    prev_clk_t = spi_clk;
    n = 0;
    idx = 0;
    while (idx < 4 && n < 4 * ByteCycles) begin
      tick(1);
      n++;
      if (spi_clk && !prev_clk_t) idx++;
      prev_clk_t = spi_clk;
    end
    if (idx < 4) check("abort rise timeout", 32'd0, 32'd1);
    reset = 1'b1;
    tick(1);
    check("abort spi_cs", 32'(spi_cs), 32'd1);
    check("abort spi_clk", 32'(spi_clk), 32'd0);
    check("abort tx_ready", 32'(tx_ready), 32'd1);
    check("abort rx_valid", 32'(rx_valid), 32'd0);
    reset = 1'b0;
    tick(ByteCycles + 10);
    check("abort no rx_valid", 32'(rxv_total - rxv0), 32'd0);
    run_byte(8'h5A, 8'hC6, 1'b0, 8'hC6, 1'b0, "after abort");

    // Three bytes issued as soon as the master will take them.
    loopback = 1'b1;
    wait_idle("multi");
    rises0   = rises_total;
    rxq.delete();
    idx      = 0;
    cs_rises = 0;
    gap      = 0;
    min_gap  = 1000;
    prev_cs  = spi_cs;
    seen_low = 1'b0;
    for (int c = 0; c < 10 * ByteCycles; c++) begin
      if (idx == 3 && rxq.size() == 3 && spi_cs && tx_ready) break;
      if (tx_ready && idx < 3) begin
        tx_data  = burst_bytes[idx];
        tx_start = 1'b1;
        idx++;
      end else begin
        tx_start = 1'b0;
      end
      tick(1);
      if (spi_cs && !prev_cs) cs_rises++;
      if (spi_cs) begin
        gap++;
      end else begin
        if (prev_cs && seen_low && gap < min_gap) min_gap = gap;
        gap      = 0;
        seen_low = 1'b1;
      end
      prev_cs = spi_cs;
      if (rx_valid) rxq.push_back(rx_data);
    end
    tx_start = 1'b0;
    check("multi rx_valid count", 32'(rxq.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("multi rx%0d", i), (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF,
            32'(burst_bytes[i]));
    end
    check("multi sck rises", 32'(rises_total - rises0), 32'd24);
`ifdef SPI_MASTER_BURST_EN
    check("burst cs rises", 32'(cs_rises), 32'd1);
`else
    check("gap cs rises", 32'(cs_rises), 32'd3);
    check("gap cs high >= 2", 32'(min_gap >= 2), 32'd1);
    check("gap cs high >= half", 32'(min_gap >= int'(HalfDiv)), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
